// File: rtl/fx2_slave_fifo_pkg.sv
// fx2_slave_fifo_pkg: shared sizing constants and endpoint address codes for the FX2 slave-FIFO bridge
package fx2_slave_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAXPKG = 512;
  localparam int LOGMAXPKG = 9;
  localparam int PKT_WORDS_DEF = 256;
  typedef enum logic [1:0] {
    EP_EP2 = 2'b00,
    EP_NONE1 = 2'b01,
    EP_EP6 = 2'b10,
    EP_NONE3 = 2'b11
  } ep_addr_t;
endpackage

// File: rtl/fx2_slave_fifo_usb_ep_fifo.sv
// usb_ep_fifo: dual-pointer endpoint FIFO with optional commit pointer and per-word last tag
// Ports: i_usb_ifclk/i_rst_n clock and async active-low reset; push/push_data write side;
// pop read side; commit closes the open packet; head_data/head_tag show the read head;
// full counts every stored word, empty only counts words visible to the reader.
module usb_ep_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 512,
  parameter bit COMMIT = 1'b0,
  parameter int PKT_WORDS = 256
) (
  input  logic         i_usb_ifclk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         commit,
  output logic [W-1:0] head_data,
  output logic         head_tag,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PKT = (AW+1)'(PKT_WORDS);
  logic [AW:0] wr_ptr, rd_ptr, cm_ptr, wr_nxt, unc_nxt, avail_ptr;
  logic [W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] tag;
  logic push_ok, pop_ok, do_commit;
  // Without a commit pointer every written word is immediately readable.
  assign avail_ptr = COMMIT ? cm_ptr : wr_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = avail_ptr == rd_ptr;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign wr_nxt = wr_ptr + (AW+1)'(push_ok);
  // Uncommitted count after this edge's write, so a same-edge write joins the packet.
  assign unc_nxt = wr_nxt - cm_ptr;
  assign do_commit = COMMIT && (unc_nxt != '0) && (commit || unc_nxt == PKT);
  assign head_data = mem[rd_ptr[AW-1:0]];
  assign head_tag = tag[rd_ptr[AW-1:0]];
  always_ff @(posedge i_usb_ifclk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  always_ff @(posedge i_usb_ifclk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cm_ptr <= '0;
      tag <= '0;
    end else begin
      // A fresh word clears any stale tag left from the previous lap unless it closes the packet.
      if (push_ok) tag[wr_ptr[AW-1:0]] <= do_commit;
      else if (do_commit) tag[wr_ptr[AW-1:0] - AW'(1)] <= 1'b1;
      wr_ptr <= wr_nxt;
      if (do_commit) cm_ptr <= wr_nxt;
      if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
endmodule

// File: rtl/fx2_slave_fifo.sv
// fx2_slave_fifo: FX2 slave-FIFO bridge, EP2 (USB OUT) to host and host to EP6 (USB IN) with packet commit
// Ports: i_usb_ifclk clock, i_rst_n async active-low reset; io_usb_data/i_usb_addr and active-low
// i_usb_slrd/slwr/sloe/pkend form the FX2 master side with o_usb_flaga (EP2 not empty) and
// o_usb_flagd (EP6 not full); i_host_wr_* pushes EP2, o_host_rd_* pops committed EP6 words;
// o_err is sticky on EP2 read-while-empty or EP6 write-while-full.
module fx2_slave_fifo
  import fx2_slave_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = MAXPKG,
  parameter int PKT_WORDS = PKT_WORDS_DEF
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst_n,
  inout  wire  [DATA_WIDTH-1:0] io_usb_data,
  input  logic [1:0]            i_usb_addr,
  input  logic                  i_usb_slrd,
  input  logic                  i_usb_slwr,
  input  logic                  i_usb_sloe,
  input  logic                  i_usb_pkend,
  output logic                  o_usb_flaga,
  output logic                  o_usb_flagd,
  input  logic [DATA_WIDTH-1:0] i_host_wr_data,
  input  logic                  i_host_wr_valid,
  output logic                  o_host_wr_ready,
  output logic [DATA_WIDTH-1:0] o_host_rd_data,
  output logic                  o_host_rd_valid,
  output logic                  o_host_rd_last,
  input  logic                  i_host_rd_ready,
  output logic                  o_err
);
  ep_addr_t ep;
  logic ep2_pop_req, ep6_push_req, ep6_commit, bus_oe;
  logic ep2_full, ep2_empty, ep2_tag_unused, ep6_full, ep6_empty, ep6_tag;
  logic [DATA_WIDTH-1:0] ep2_head;
  assign ep = ep_addr_t'(i_usb_addr);
  assign ep2_pop_req = !i_usb_slrd && ep == EP_EP2;
  assign ep6_push_req = !i_usb_slwr && ep == EP_EP6;
  assign ep6_commit = !i_usb_pkend && ep == EP_EP6;
  // Reset also releases the bus so it floats without waiting for a clock.
  assign bus_oe = i_rst_n && !i_usb_sloe && ep == EP_EP2;
  assign io_usb_data = bus_oe ? (ep2_empty ? '0 : ep2_head) : 'z;
  assign o_usb_flaga = !ep2_empty;
  assign o_usb_flagd = !ep6_full;
  assign o_host_wr_ready = !ep2_full;
  assign o_host_rd_valid = !ep6_empty;
  assign o_host_rd_last = !ep6_empty && ep6_tag;
  usb_ep_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH), .COMMIT(1'b0), .PKT_WORDS(PKT_WORDS)) u_ep2 (
    .i_usb_ifclk(i_usb_ifclk),
    .i_rst_n(i_rst_n),
    .push(i_host_wr_valid),
    .push_data(i_host_wr_data),
    .pop(ep2_pop_req),
    .commit(1'b0),
    .head_data(ep2_head),
    .head_tag(ep2_tag_unused),
    .full(ep2_full),
    .empty(ep2_empty)
  );
  usb_ep_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH), .COMMIT(1'b1), .PKT_WORDS(PKT_WORDS)) u_ep6 (
    .i_usb_ifclk(i_usb_ifclk),
    .i_rst_n(i_rst_n),
    .push(ep6_push_req),
    .push_data(io_usb_data),
    .pop(i_host_rd_ready),
    .commit(ep6_commit),
    .head_data(o_host_rd_data),
    .head_tag(ep6_tag),
    .full(ep6_full),
    .empty(ep6_empty)
  );
  always_ff @(posedge i_usb_ifclk or negedge i_rst_n)
    if (!i_rst_n) o_err <= 1'b0;
    else if ((ep2_pop_req && ep2_empty) || (ep6_push_req && ep6_full)) o_err <= 1'b1;
endmodule

// File: tb/tb_fx2_slave_fifo.sv
// tb_fx2_slave_fifo: vector table, corner sequences and random traffic against a queue model
module tb_fx2_slave_fifo;
  localparam int DEPTH = 512;
  localparam int PKT = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] addr;
  logic slrd, slwr, sloe, pkend, wv, rr;
  logic [15:0] wd, bd, rdata;
  wire [15:0] bus;
  logic flaga, flagd, wready, rvalid, rlast, err;
  assign bus = (addr == 2'b00 && !sloe) ? 16'bz : bd;
  fx2_slave_fifo #(.DATA_WIDTH(16), .DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
    .i_usb_ifclk(clk), .i_rst_n(rst_n), .io_usb_data(bus), .i_usb_addr(addr),
    .i_usb_slrd(slrd), .i_usb_slwr(slwr), .i_usb_sloe(sloe), .i_usb_pkend(pkend),
    .o_usb_flaga(flaga), .o_usb_flagd(flagd),
    .i_host_wr_data(wd), .i_host_wr_valid(wv), .o_host_wr_ready(wready),
    .o_host_rd_data(rdata), .o_host_rd_valid(rvalid), .o_host_rd_last(rlast),
    .i_host_rd_ready(rr), .o_err(err)
  );
  int checks = 0;
  int errors = 0;
  logic [15:0] q2[$];
  logic [15:0] q6u[$];
  logic [16:0] q6c[$];
  bit merr;
  typedef struct {
    logic [1:0] addr;
    logic slrd, slwr, sloe, pkend, wv, rr;
    logic [15:0] din;
    logic fa, fd, rv, rl;
    logic [15:0] rdd;
    logic er;
    logic [15:0] bx;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t mk(logic [1:0] a, logic r, logic w, logic oe, logic pe, logic hv, logic hr,
                              logic [15:0] d, logic fa, logic fd, logic rv, logic rl, logic [15:0] rdd,
                              logic er, logic [15:0] bx);
    vec_t v;
    v.addr = a; v.slrd = r; v.slwr = w; v.sloe = oe; v.pkend = pe; v.wv = hv; v.rr = hr; v.din = d;
    v.fa = fa; v.fd = fd; v.rv = rv; v.rl = rl; v.rdd = rdd; v.er = er; v.bx = bx;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic idle();
    addr = 2'b01; slrd = 1; slwr = 1; sloe = 1; pkend = 1; wv = 0; rr = 0; wd = '0; bd = '0;
  endtask
  task automatic clear_model();
    q2.delete(); q6u.delete(); q6c.delete(); merr = 0;
  endtask
  task automatic compare();
    chk("flaga", 32'(flaga), 32'(q2.size() > 0));
    chk("flagd", 32'(flagd), 32'(q6u.size() + q6c.size() < DEPTH));
    chk("wr_ready", 32'(wready), 32'(q2.size() < DEPTH));
    chk("rd_valid", 32'(rvalid), 32'(q6c.size() > 0));
    if (q6c.size() > 0) chk("rd_word", 32'({rlast, rdata}), 32'(q6c[0]));
    chk("err", 32'(err), 32'(merr));
    if (addr == 2'b00 && !sloe) chk("bus", 32'(bus), 32'(q2.size() > 0 ? q2[0] : 16'h0));
  endtask
  task automatic model_edge();
    int n2, n6;
    logic [16:0] x;
    n2 = q2.size();
    n6 = q6u.size() + q6c.size();
    if (addr == 2'b00 && !slrd) begin
      if (n2 > 0) x = 17'(q2.pop_front());
      else merr = 1;
    end
    if (wv && n2 < DEPTH) q2.push_back(wd);
    if (rr && q6c.size() > 0) x = q6c.pop_front();
    if (addr == 2'b10 && !slwr) begin
      if (n6 < DEPTH) q6u.push_back(bd);
      else merr = 1;
    end
    if (((addr == 2'b10 && !pkend) || q6u.size() == PKT) && q6u.size() > 0) begin
      foreach (q6u[i]) q6c.push_back({i == q6u.size() - 1, q6u[i]});
      q6u.delete();
    end
  endtask
  task automatic step();
    @(negedge clk);
    compare();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst_n = 0;
    clear_model();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int r;
    idle();
    do_reset();
    vt.push_back(mk(2'b01,1,1,1,1,0,0,16'h0000, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,1,0,16'h0001, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,1,0,16'h0002, 1,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,1,0,16'h0003, 1,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,1,0,16'h0004, 1,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b00,0,1,0,1,0,0,16'h0000, 1,1,0,0,16'h0000,0,16'h0001));
    vt.push_back(mk(2'b00,0,1,0,1,0,0,16'h0000, 1,1,0,0,16'h0000,0,16'h0002));
    vt.push_back(mk(2'b00,0,1,0,1,0,0,16'h0000, 1,1,0,0,16'h0000,0,16'h0003));
    vt.push_back(mk(2'b00,0,1,0,1,0,0,16'h0000, 1,1,0,0,16'h0000,0,16'h0004));
    vt.push_back(mk(2'b01,1,1,1,1,0,0,16'h0000, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b10,1,0,1,1,0,0,16'hA5A0, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b10,1,0,1,1,0,0,16'hA5A1, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b10,1,0,1,1,0,0,16'hA5A2, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b10,1,1,1,0,0,0,16'h0000, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,0,1,16'h0000, 0,1,1,0,16'hA5A0,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,0,1,16'h0000, 0,1,1,0,16'hA5A1,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,0,1,16'h0000, 0,1,1,1,16'hA5A2,0,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,0,0,16'h0000, 0,1,0,0,16'h0000,0,16'h0));
    vt.push_back(mk(2'b00,0,1,0,1,0,0,16'h0000, 0,1,0,0,16'h0000,0,16'h0000));
    vt.push_back(mk(2'b01,1,1,1,1,0,0,16'h0000, 0,1,0,0,16'h0000,1,16'h0));
    vt.push_back(mk(2'b01,0,0,0,0,0,0,16'h1111, 0,1,0,0,16'h0000,1,16'h0));
    vt.push_back(mk(2'b11,0,0,0,0,0,0,16'h2222, 0,1,0,0,16'h0000,1,16'h0));
    vt.push_back(mk(2'b10,0,1,0,1,0,0,16'h3333, 0,1,0,0,16'h0000,1,16'h0));
    vt.push_back(mk(2'b00,1,0,1,1,0,0,16'h1234, 0,1,0,0,16'h0000,1,16'h0));
    vt.push_back(mk(2'b10,1,1,1,0,0,0,16'h0000, 0,1,0,0,16'h0000,1,16'h0));
    vt.push_back(mk(2'b01,1,1,1,1,0,0,16'h0000, 0,1,0,0,16'h0000,1,16'h0));
    foreach (vt[i]) begin
      addr = vt[i].addr; slrd = vt[i].slrd; slwr = vt[i].slwr; sloe = vt[i].sloe; pkend = vt[i].pkend;
      wv = vt[i].wv; rr = vt[i].rr; wd = vt[i].din; bd = vt[i].din;
      #2;
      chk($sformatf("vec%0d_flaga", i), 32'(flaga), 32'(vt[i].fa));
      chk($sformatf("vec%0d_flagd", i), 32'(flagd), 32'(vt[i].fd));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rvalid), 32'(vt[i].rv));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].er));
      if (vt[i].rv) chk($sformatf("vec%0d_rd_word", i), 32'({rlast, rdata}), 32'({vt[i].rl, vt[i].rdd}));
      if (vt[i].addr == 2'b00 && !vt[i].sloe) chk($sformatf("vec%0d_bus", i), 32'(bus), 32'(vt[i].bx));
      step();
    end
    do_reset();
    for (int i = 0; i < PKT; i++) begin
      idle(); addr = 2'b10; slwr = 0; bd = 16'(16'h4000 + i);
      step();
    end
    idle();
    chk("auto_valid", 32'(rvalid), 32'd1);
    addr = 2'b10; pkend = 0;
    step();
    idle(); rr = 1;
    for (int i = 0; i < PKT; i++) begin
      chk("auto_last", 32'({rvalid, rlast}), 32'({1'b1, i == PKT - 1}));
      step();
    end
    idle();
    chk("auto_zlp_valid", 32'(rvalid), 32'd0);
    chk("auto_zlp_err", 32'(err), 32'd0);
    step();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); addr = 2'b10; slwr = 0; bd = 16'($urandom);
      step();
    end
    idle();
    chk("fill_flagd", 32'(flagd), 32'd0);
    chk("fill_err0", 32'(err), 32'd0);
    addr = 2'b10; slwr = 0; bd = 16'hDEAD;
    step();
    idle();
    chk("fill_err1", 32'(err), 32'd1);
    rr = 1;
    step();
    idle();
    chk("fill_drain_flagd", 32'(flagd), 32'd1);
    step();
    do_reset();
    wv = 1;
    for (int i = 1; i <= 2; i++) begin
      wd = 16'(i);
      step();
    end
    for (int k = 0; k < 600; k++) begin
      addr = 2'b00; sloe = 0; slrd = 0; wv = 1; wd = 16'(k + 3);
      #1;
      chk("wrap_bus", 32'(bus), 32'(16'(k + 1)));
      step();
    end
    idle();
    chk("wrap_ready", 32'(wready), 32'd1);
    step();
    do_reset();
    addr = 2'b00; sloe = 0; slrd = 0;
    step();
    idle(); wv = 1;
    for (int i = 0; i < 3; i++) begin
      wd = 16'(i + 7);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      idle(); addr = 2'b10; slwr = 0; bd = 16'(16'h0100 + i); pkend = (i == 2) ? 1'b0 : 1'b1;
      step();
    end
    idle();
    step();
    #2;
    rst_n = 0;
    #1;
    chk("rst_flaga", 32'(flaga), 32'd0);
    chk("rst_flagd", 32'(flagd), 32'd1);
    chk("rst_rd_valid", 32'(rvalid), 32'd0);
    chk("rst_rd_last", 32'(rlast), 32'd0);
    chk("rst_wr_ready", 32'(wready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    step();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 7);
      addr = r < 3 ? 2'b00 : r < 6 ? 2'b10 : r == 6 ? 2'b01 : 2'b11;
      slrd = 1'($urandom % 2);
      slwr = 1'($urandom % 2);
      sloe = 1'($urandom % 4 == 0);
      pkend = 1'($urandom_range(0, 9) != 0);
      wv = 1'($urandom % 2);
      rr = 1'($urandom % 3 != 0);
      wd = 16'($urandom);
      bd = 16'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
